// File: rtl/nrzi_unstuff_decoder.sv
// NRZI line decoder with bit-unstuffing: turns sampled line levels into data bits,
// drops the stuffed 0 after a run of ones and flags a 1 found where a stuff bit belongs.
module nrzi_unstuff_decoder #(
   parameter bit          INITIAL_VALUE      = 1'b1,
   parameter bit          ZERO_AS_TRANSITION = 1'b1,
   parameter int unsigned STUFF_RUN          = 6,
   parameter bit          STUFF_EN           = 1'b1
) (
   input  logic clk12_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic sample_en_i,
   input  logic data_i,
   output logic data_o,
   output logic valid_o,
   output logic stuff_err_o
);

   localparam int unsigned CntW = $clog2(STUFF_RUN + 1);
   localparam logic [CntW-1:0] RunMax = CntW'(STUFF_RUN);

   // Declaration initialisers make the power-up state match the reset state.
   logic            prev_level_q = INITIAL_VALUE;
   logic            prev_level_d;
   logic [CntW-1:0] ones_cnt_q = '0;
   logic [CntW-1:0] ones_cnt_d;
   logic            data_q = INITIAL_VALUE;
   logic            data_d;
   logic            valid_q = 1'b0;
   logic            valid_d;
   logic            stuff_err_q = 1'b0;
   logic            stuff_err_d;

   logic            dec_bit;
   logic            stuff_slot;

   always_comb begin
      if (ZERO_AS_TRANSITION) begin
         dec_bit = ~(prev_level_q ^ data_i);
      end else begin
         dec_bit = prev_level_q ^ data_i;
      end
      stuff_slot = STUFF_EN && (ones_cnt_q == RunMax);
   end

   always_comb begin
      prev_level_d = prev_level_q;
      ones_cnt_d   = ones_cnt_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      stuff_err_d  = 1'b0;

      if (clear_i) begin
         // A strobe coinciding with clear is dropped entirely.
         prev_level_d = INITIAL_VALUE;
         ones_cnt_d   = '0;
         data_d       = INITIAL_VALUE;
      end else if (sample_en_i) begin
         prev_level_d = data_i;
         if (stuff_slot) begin
            ones_cnt_d  = '0;
            stuff_err_d = dec_bit;
         end else begin
            data_d  = dec_bit;
            valid_d = 1'b1;
            if (STUFF_EN) begin
               ones_cnt_d = dec_bit ? ones_cnt_q + CntW'(1) : '0;
            end
         end
      end
   end

   always_ff @(posedge clk12_i) begin
      if (rst_i) begin
         prev_level_q <= INITIAL_VALUE;
         ones_cnt_q   <= '0;
         data_q       <= INITIAL_VALUE;
         valid_q      <= 1'b0;
         stuff_err_q  <= 1'b0;
      end else begin
         prev_level_q <= prev_level_d;
         ones_cnt_q   <= ones_cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         stuff_err_q  <= stuff_err_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign stuff_err_o = stuff_err_q;

endmodule

// File: tb/tb_nrzi_unstuff_decoder.sv
// Bench for nrzi_unstuff_decoder: directed scenarios plus random traffic, all checked
// against a level/run-length reference model; a second instance covers the alternate config.
module tb_nrzi_unstuff_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic smp = 1'b0;
   logic lvl = 1'b1;
   logic data_o, valid_o, err_o;
   logic data2_o, valid2_o, err2_o;

   int total = 0;
   int bad = 0;

   // Reference model state.
   logic m_prev = 1'b1;
   logic m_data = 1'b1;
   int   m_run = 0;
   logic a_prev = 1'b1;
   logic a_data = 1'b1;
   logic e_data, e_valid, e_err, e_data2, e_valid2;

   nrzi_unstuff_decoder dut (
      .clk12_i    (clk),
      .rst_i      (rst),
      .clear_i    (clr),
      .sample_en_i(smp),
      .data_i     (lvl),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .stuff_err_o(err_o)
   );

   nrzi_unstuff_decoder #(
      .ZERO_AS_TRANSITION(1'b0),
      .STUFF_EN          (1'b0)
   ) dut2 (
      .clk12_i    (clk),
      .rst_i      (rst),
      .clear_i    (clr),
      .sample_en_i(smp),
      .data_i     (lvl),
      .data_o     (data2_o),
      .valid_o    (valid2_o),
      .stuff_err_o(err2_o)
   );

   always #5 clk = ~clk;

   // Drive one cycle and advance the model; leaves time at #1 after the edge.
   task automatic step(input logic r, input logic c, input logic s, input logic l);
      logic dd, da;
      rst = r; clr = c; smp = s; lvl = l;
      @(posedge clk);
      e_valid = 1'b0; e_err = 1'b0; e_valid2 = 1'b0;
      if (r || c) begin
         m_prev = 1'b1; m_data = 1'b1; m_run = 0;
         a_prev = 1'b1; a_data = 1'b1;
      end else if (s) begin
         dd = (l == m_prev);
         da = (l != a_prev);
         m_prev = l;
         a_prev = l;
         if (m_run == 6) begin
            m_run = 0;
            e_err = dd;
         end else begin
            m_data  = dd;
            e_valid = 1'b1;
            m_run   = dd ? m_run + 1 : 0;
         end
         a_data   = da;
         e_valid2 = 1'b1;
      end
      e_data = m_data;
      e_data2 = a_data;
      #1;
   endtask

   task automatic test_reset();
      total++;
      if ({data_o, valid_o, err_o} !== 3'b100) begin
         bad++;
         $display("FAIL powerup: got d/v/e=%b%b%b want 100", data_o, valid_o, err_o);
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         total++;
         if ({data_o, valid_o, err_o} !== 3'b100 || dut.ones_cnt_q !== 3'd0) begin
            bad++;
            $display("FAIL reset %0d: got d/v/e=%b%b%b cnt=%0d want 100 cnt=0",
                     i, data_o, valid_o, err_o, dut.ones_cnt_q);
         end
      end
   endtask

   task automatic test_stuff();
      logic lv [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      int n_ones = 0;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, lv[i]);
         if (valid_o && data_o) n_ones++;
         total++;
         if ({valid_o, err_o, data_o} !== {e_valid, e_err, e_data}) begin
            bad++;
            $display("FAIL stuff step %0d: got v/e/d=%b%b%b want %b%b%b",
                     i, valid_o, err_o, data_o, e_valid, e_err, e_data);
         end
      end
      total++;
      if (n_ones != 7 || dut.ones_cnt_q !== 3'(m_run)) begin
         bad++;
         $display("FAIL stuff summary: got ones=%0d cnt=%0d want ones=7 cnt=%0d",
                  n_ones, dut.ones_cnt_q, m_run);
      end
   endtask

   task automatic test_stuff_err();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1);
         total++;
         if ({valid_o, err_o, data_o} !== {e_valid, e_err, e_data} ||
             (i == 6 && {valid_o, err_o} !== 2'b01)) begin
            bad++;
            $display("FAIL stuff_err step %0d: got v/e/d=%b%b%b want %b%b%b",
                     i, valid_o, err_o, data_o, e_valid, e_err, e_data);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (err_o !== 1'b0 || dut.ones_cnt_q !== 3'd0) begin
         bad++;
         $display("FAIL stuff_err after: got err=%b cnt=%0d want err=0 cnt=0",
                  err_o, dut.ones_cnt_q);
      end
   endtask

   task automatic test_gap();
      logic sv [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
      logic lv [10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, sv[i], lv[i]);
         total++;
         if ({valid_o, err_o, data_o} !== {e_valid, e_err, e_data} ||
             (i == 9 && {valid_o, err_o} !== 2'b00)) begin
            bad++;
            $display("FAIL gap step %0d: got v/e/d=%b%b%b want %b%b%b",
                     i, valid_o, err_o, data_o, e_valid, e_err, e_data);
         end
      end
   endtask

   task automatic test_clear();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, (i == 5), 1'b1, (i < 7));
         total++;
         if ({valid_o, err_o, data_o} !== {e_valid, e_err, e_data} ||
             dut.ones_cnt_q !== 3'(m_run)) begin
            bad++;
            $display("FAIL clear step %0d: got v/e/d=%b%b%b cnt=%0d want %b%b%b cnt=%0d",
                     i, valid_o, err_o, data_o, dut.ones_cnt_q,
                     e_valid, e_err, e_data, m_run);
         end
      end
   endtask

   task automatic test_alt_config();
      logic lv [4] = '{1, 0, 0, 1};
      logic ex [4] = '{0, 1, 0, 1};
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, lv[i]);
         total++;
         if ({valid2_o, err2_o, data2_o} !== {1'b1, 1'b0, ex[i]} || e_data2 !== ex[i]) begin
            bad++;
            $display("FAIL alt step %0d: got v/e/d=%b%b%b want 10%b",
                     i, valid2_o, err2_o, data2_o, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if ({data_o, valid_o} !== 2'b10) begin
         bad++;
         $display("FAIL reset_mid in reset: got d/v=%b%b want 10", data_o, valid_o);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      total++;
      if ({data_o, valid_o, err_o} !== 3'b110 || e_data !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid after: got d/v/e=%b%b%b want 110", data_o, valid_o, err_o);
      end
   endtask

   task automatic test_random();
      logic r, c, s, l;
      step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         c = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 9) < 7);
         // Mostly repeat the previous level so long runs of ones reach the stuff slot.
         l = ($urandom_range(0, 9) < 8) ? m_prev : ~m_prev;
         step(r, c, s, l);
         total++;
         if ({valid_o, err_o, data_o} !== {e_valid, e_err, e_data} ||
             {valid2_o, err2_o, data2_o} !== {e_valid2, 1'b0, e_data2} ||
             dut.ones_cnt_q !== 3'(m_run)) begin
            bad++;
            $display("FAIL random step %0d: got v/e/d=%b%b%b v2/e2/d2=%b%b%b cnt=%0d want %b%b%b %b0%b cnt=%0d",
                     i, valid_o, err_o, data_o, valid2_o, err2_o, data2_o, dut.ones_cnt_q,
                     e_valid, e_err, e_data, e_valid2, e_data2, m_run);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_stuff();
      test_stuff_err();
      test_gap();
      test_clear();
      test_alt_config();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
